axis_demux_sched: RTL and testbench



---
 rtl/axis_demux_sched.sv | 158 +++++++++++++++
 tb/tb_axis_demux_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_demux_sched.sv
// Per-frame round-robin scheduler for a stream demux. It picks an output that is
// enabled and has credit, holds sel for the whole frame, and tracks per-output credits.
module axis_demux_sched #(
    parameter int M_COUNT            = 4,
    parameter int MAX_CREDITS        = 4,
    parameter bit DROP_WHEN_DISABLED = 1'b0,
    parameter int SW                 = ($clog2(M_COUNT) > 0 ? $clog2(M_COUNT) : 1),
    parameter int CW                 = $clog2(MAX_CREDITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    // Handshake: a beat moves when mon_tvalid and mon_tready are both high at a rising
    // edge. mon_tready already includes demux_enable, and mon_tlast marks the final beat.
    input  logic                  mon_tvalid,
    input  logic                  mon_tready,
    input  logic                  mon_tlast,
    input  logic [M_COUNT-1:0]    port_enable,
    input  logic [M_COUNT-1:0]    frame_done,
    output logic                  demux_enable,
    output logic                  demux_drop,
    output logic [SW-1:0]         demux_sel,
    output logic                  credit_err,
    output logic                  busy,
    output logic [1:0]            dbg_state,
    output logic [M_COUNT*CW-1:0] dbg_credit
);
    localparam logic [1:0]    ST_IDLE    = 2'd0;
    localparam logic [1:0]    ST_GRANT   = 2'd1;
    localparam logic [1:0]    ST_FRAME   = 2'd2;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(MAX_CREDITS);
    localparam logic [CW-1:0] CREDIT_ONE = CW'(1);
    localparam logic [SW-1:0] PTR_INIT   = SW'(M_COUNT - 1);

    logic [1:0]         state;
    logic [SW-1:0]      last_ptr;
    logic [CW-1:0]      credit [M_COUNT];
    logic [M_COUNT-1:0] eligible;
    logic [M_COUNT-1:0] consume;
    logic               beat;
    logic               frame_end;
    logic               revoke;
    logic               grant_drop;
    logic               found;
    logic [SW-1:0]      pick;
    logic [SW-1:0]      cand;

    assign beat       = mon_tvalid & mon_tready;
    assign frame_end  = beat & mon_tlast;
    assign revoke     = (state == ST_GRANT) & ~beat & ~demux_drop & ~port_enable[demux_sel];
    assign grant_drop = DROP_WHEN_DISABLED & (port_enable == '0);
    assign dbg_state  = state;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < M_COUNT; i++) begin
            eligible[i] = port_enable[i] & (credit[i] != '0);
        end
    end

    // Search starts just after the last granted port and wraps; first hit wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= M_COUNT; k++) begin
            cand = SW'((int'(last_ptr) + k) % M_COUNT);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // A credit is spent on the first accepted beat, never at grant time, so a revoked
    // grant costs nothing.
    always_comb begin
        consume = '0;
        if ((state == ST_GRANT) && beat && !demux_drop) begin
            consume[demux_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            last_ptr     <= PTR_INIT;
            demux_sel    <= '0;
            demux_drop   <= 1'b0;
            demux_enable <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        state        <= ST_GRANT;
                        demux_sel    <= pick;
                        last_ptr     <= pick;
                        demux_drop   <= 1'b0;
                        demux_enable <= 1'b1;
                        busy         <= 1'b1;
                    end else if (grant_drop) begin
                        state        <= ST_GRANT;
                        demux_drop   <= 1'b1;
                        demux_enable <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (frame_end || revoke) begin
                        state        <= ST_IDLE;
                        demux_enable <= 1'b0;
                        busy         <= 1'b0;
                    end else if (beat) begin
                        state <= ST_FRAME;
                    end
                end
                ST_FRAME: begin
                    if (frame_end) begin
                        state        <= ST_IDLE;
                        demux_enable <= 1'b0;
                        busy         <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    demux_enable <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

    // A return that meets a full counter is a protocol error and is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < M_COUNT; i++) begin
                credit[i] <= CREDIT_MAX;
            end
            credit_err <= 1'b0;
        end else begin
            for (int i = 0; i < M_COUNT; i++) begin
                if (consume[i] && !frame_done[i]) begin
                    credit[i] <= credit[i] - CREDIT_ONE;
                end else if (frame_done[i] && !consume[i]) begin
                    if (credit[i] == CREDIT_MAX) begin
                        credit_err <= 1'b1;
                    end else begin
                        credit[i] <= credit[i] + CREDIT_ONE;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < M_COUNT; g++) begin : g_dbg
        assign dbg_credit[g*CW +: CW] = credit[g];
    end
endmodule

// File: tb/tb_axis_demux_sched.sv
// Directed bench for axis_demux_sched: a table of frame grants plus hand-written
// sequences for revoke, drop mode, simultaneous credit events and reset mid-frame.
module tb_axis_demux_sched;
    localparam int M_COUNT     = 4;
    localparam int MAX_CREDITS = 4;
    localparam int SW          = 2;
    localparam int CW          = 3;
    localparam logic [M_COUNT*CW-1:0] FULL_CR = {3'd4, 3'd4, 3'd4, 3'd4};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mon_tvalid = 1'b0;
    logic mon_tlast  = 1'b0;
    logic [M_COUNT-1:0] port_enable = '0;
    logic [M_COUNT-1:0] frame_done  = '0;

    // Instance a: normal stall mode. Instance b: drop-when-disabled mode.
    logic tready_a, en_a, drop_a, err_a, busy_a;
    logic tready_b, en_b, drop_b, err_b, busy_b;
    logic [SW-1:0] sel_a, sel_b;
    logic [1:0] st_a, st_b;
    logic [M_COUNT*CW-1:0] cr_a, cr_b;

    // The demux gates its tready with enable; the source is always ready here.
    assign tready_a = en_a;
    assign tready_b = en_b;

    axis_demux_sched #(.M_COUNT(M_COUNT), .MAX_CREDITS(MAX_CREDITS), .DROP_WHEN_DISABLED(1'b0)) u_dut (
        .clk(clk), .rst(rst), .mon_tvalid(mon_tvalid), .mon_tready(tready_a), .mon_tlast(mon_tlast),
        .port_enable(port_enable), .frame_done(frame_done), .demux_enable(en_a), .demux_drop(drop_a),
        .demux_sel(sel_a), .credit_err(err_a), .busy(busy_a), .dbg_state(st_a), .dbg_credit(cr_a)
    );

    axis_demux_sched #(.M_COUNT(M_COUNT), .MAX_CREDITS(MAX_CREDITS), .DROP_WHEN_DISABLED(1'b1)) u_drop (
        .clk(clk), .rst(rst), .mon_tvalid(mon_tvalid), .mon_tready(tready_b), .mon_tlast(mon_tlast),
        .port_enable(port_enable), .frame_done(frame_done), .demux_enable(en_b), .demux_drop(drop_b),
        .demux_sel(sel_b), .credit_err(err_b), .busy(busy_b), .dbg_state(st_b), .dbg_credit(cr_b)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required finish before 300000");
        $fatal(1);
    end

    typedef struct {
        bit                    rst_before;
        logic [M_COUNT-1:0]    pen;
        int                    beats;
        logic [SW-1:0]         exp_sel;
        bit                    chk_cr;
        logic [M_COUNT*CW-1:0] exp_cr;
    } vec_t;

    vec_t vec [16];
    logic [SW-1:0] exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    bit ok;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit r, input logic [3:0] pen, input int beats,
                                input logic [SW-1:0] sel, input bit cc,
                                input logic [M_COUNT*CW-1:0] cr);
        vec_t v;
        v.rst_before = r;
        v.pen        = pen;
        v.beats      = beats;
        v.exp_sel    = sel;
        v.chk_cr     = cc;
        v.exp_cr     = cr;
        return v;
    endfunction

    function automatic logic [CW-1:0] credit_of(input bit b, input int i);
        return b ? cr_b[i*CW +: CW] : cr_a[i*CW +: CW];
    endfunction

    // Driver tasks: all start and end on a falling edge.
    task automatic do_reset();
        rst        = 1'b1;
        mon_tvalid = 1'b0;
        mon_tlast  = 1'b0;
        frame_done = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_grant(input bit b, input int limit, output int cycles, output bit seen);
        cycles = 0;
        while (!(b ? en_b : en_a) && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
        seen = b ? en_b : en_a;
    endtask

    task automatic wait_beat(input bit b);
        int n;
        n = 0;
        while (!(b ? tready_b : tready_a) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("beat_ready", {31'd0, (b ? tready_b : tready_a)}, 32'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_frame(input bit b, input int beats, input logic [M_COUNT-1:0] first_done);
        for (int k = 0; k < beats; k++) begin
            mon_tvalid = 1'b1;
            mon_tlast  = (k == beats - 1);
            if (k == 0) frame_done = first_done;
            wait_beat(b);
            frame_done = '0;
        end
        mon_tvalid = 1'b0;
        mon_tlast  = 1'b0;
    endtask

    task automatic pulse_done(input logic [M_COUNT-1:0] mask);
        frame_done = mask;
        @(negedge clk);
        frame_done = '0;
    endtask

    initial begin
        // Round-robin over all four ports, three-beat frames.
        vec[0]  = mk(1, 4'b1111, 3, 2'd0, 0, FULL_CR);
        vec[1]  = mk(0, 4'b1111, 3, 2'd1, 0, FULL_CR);
        vec[2]  = mk(0, 4'b1111, 3, 2'd2, 0, FULL_CR);
        vec[3]  = mk(0, 4'b1111, 3, 2'd3, 1, {3'd3, 3'd3, 3'd3, 3'd3});
        vec[4]  = mk(0, 4'b1111, 3, 2'd0, 0, FULL_CR);
        vec[5]  = mk(0, 4'b1111, 3, 2'd1, 0, FULL_CR);
        vec[6]  = mk(0, 4'b1111, 3, 2'd2, 0, FULL_CR);
        vec[7]  = mk(0, 4'b1111, 3, 2'd3, 1, {3'd2, 3'd2, 3'd2, 3'd2});
        // Only ports 1 and 3 enabled, single-beat frames until their credits run out.
        vec[8]  = mk(1, 4'b1010, 1, 2'd1, 0, FULL_CR);
        vec[9]  = mk(0, 4'b1010, 1, 2'd3, 0, FULL_CR);
        vec[10] = mk(0, 4'b1010, 1, 2'd1, 0, FULL_CR);
        vec[11] = mk(0, 4'b1010, 1, 2'd3, 1, {3'd2, 3'd4, 3'd2, 3'd4});
        vec[12] = mk(0, 4'b1010, 1, 2'd1, 0, FULL_CR);
        vec[13] = mk(0, 4'b1010, 1, 2'd3, 0, FULL_CR);
        vec[14] = mk(0, 4'b1010, 1, 2'd1, 0, FULL_CR);
        vec[15] = mk(0, 4'b1010, 1, 2'd3, 1, {3'd0, 3'd4, 3'd0, 3'd4});

        // Reset values
        do_reset();
        check("rst_enable", {31'd0, en_a}, 32'd0);
        check("rst_drop", {31'd0, drop_a}, 32'd0);
        check("rst_sel", {30'd0, sel_a}, 32'd0);
        check("rst_err", {31'd0, err_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_state", {30'd0, st_a}, 32'd0);
        check("rst_credits", {20'd0, cr_a}, {20'd0, FULL_CR});

        // Table-driven frames
        for (int r = 0; r < 16; r++) begin
            if (vec[r].rst_before) do_reset();
            port_enable = vec[r].pen;
            exp_q.push_back(vec[r].exp_sel);
            wait_grant(0, 10, cyc, ok);
            check("grant_seen", {31'd0, ok}, 32'd1);
            check("bubble_cycles", cyc, 32'd1);
            check("grant_sel", {30'd0, sel_a}, {30'd0, exp_q.pop_front()});
            check("grant_drop", {31'd0, drop_a}, 32'd0);
            check("grant_busy", {31'd0, busy_a}, 32'd1);
            send_frame(0, vec[r].beats, '0);
            check("enable_after_tlast", {31'd0, en_a}, 32'd0);
            if (vec[r].chk_cr) check("table_credits", {20'd0, cr_a}, {20'd0, vec[r].exp_cr});
        end

        // Exhausted: no further grant until a credit returns, and the return is seen a cycle later.
        wait_grant(0, 6, cyc, ok);
        check("exhausted_no_grant", {31'd0, ok}, 32'd0);
        pulse_done(4'b1000);
        check("no_same_cycle_grant", {31'd0, en_a}, 32'd0);
        check("returned_credit3", {29'd0, credit_of(0, 3)}, 32'd1);
        wait_grant(0, 10, cyc, ok);
        check("regrant_cycles", cyc, 32'd1);
        check("regrant_sel", {30'd0, sel_a}, 32'd3);
        send_frame(0, 1, '0);
        check("credit3_spent", {29'd0, credit_of(0, 3)}, 32'd0);

        // Revoke before the first beat
        do_reset();
        port_enable = 4'b1111;
        for (int f = 0; f < 2; f++) begin
            wait_grant(0, 10, cyc, ok);
            send_frame(0, 1, '0);
        end
        wait_grant(0, 10, cyc, ok);
        check("revoke_grant_sel", {30'd0, sel_a}, 32'd2);
        port_enable = 4'b1011;
        @(negedge clk);
        check("revoke_enable", {31'd0, en_a}, 32'd0);
        check("revoke_busy", {31'd0, busy_a}, 32'd0);
        check("revoke_credit2", {29'd0, credit_of(0, 2)}, 32'd4);
        wait_grant(0, 10, cyc, ok);
        check("after_revoke_cycles", cyc, 32'd1);
        check("after_revoke_sel", {30'd0, sel_a}, 32'd3);
        send_frame(0, 1, '0);
        check("after_revoke_credit3", {29'd0, credit_of(0, 3)}, 32'd3);

        // Drop mode with every port disabled
        do_reset();
        port_enable = 4'b0000;
        wait_grant(1, 10, cyc, ok);
        check("drop_grant_seen", {31'd0, ok}, 32'd1);
        check("drop_grant_cycles", cyc, 32'd1);
        for (int k = 0; k < 4; k++) begin
            mon_tvalid = 1'b1;
            mon_tlast  = (k == 3);
            check("drop_enable", {31'd0, en_b}, 32'd1);
            check("drop_flag", {31'd0, drop_b}, 32'd1);
            wait_beat(1);
        end
        mon_tvalid = 1'b0;
        mon_tlast  = 1'b0;
        check("drop_idle_enable", {31'd0, en_b}, 32'd0);
        check("drop_idle_state", {30'd0, st_b}, 32'd0);
        check("drop_credits", {20'd0, cr_b}, {20'd0, FULL_CR});
        check("stall_mode_no_grant", {31'd0, en_a}, 32'd0);

        // Simultaneous consume and return, then a return into a full counter
        do_reset();
        port_enable = 4'b0001;
        wait_grant(0, 10, cyc, ok);
        check("simul_sel", {30'd0, sel_a}, 32'd0);
        send_frame(0, 2, 4'b0001);
        check("simul_credit0", {29'd0, credit_of(0, 0)}, 32'd4);
        check("simul_err_clear", {31'd0, err_a}, 32'd0);
        pulse_done(4'b0010);
        check("overflow_credit1", {29'd0, credit_of(0, 1)}, 32'd4);
        check("overflow_err", {31'd0, err_a}, 32'd1);
        repeat (3) @(negedge clk);
        check("overflow_err_sticky", {31'd0, err_a}, 32'd1);

        // Reset in the middle of a frame on port 1
        do_reset();
        check("err_cleared_by_rst", {31'd0, err_a}, 32'd0);
        port_enable = 4'b1111;
        wait_grant(0, 10, cyc, ok);
        send_frame(0, 1, '0);
        wait_grant(0, 10, cyc, ok);
        check("midrst_grant_sel", {30'd0, sel_a}, 32'd1);
        mon_tvalid = 1'b1;
        mon_tlast  = 1'b0;
        wait_beat(0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst        = 1'b0;
        mon_tvalid = 1'b0;
        check("midrst_enable", {31'd0, en_a}, 32'd0);
        check("midrst_sel", {30'd0, sel_a}, 32'd0);
        check("midrst_busy", {31'd0, busy_a}, 32'd0);
        check("midrst_credits", {20'd0, cr_a}, {20'd0, FULL_CR});
        wait_grant(0, 10, cyc, ok);
        check("midrst_next_sel", {30'd0, sel_a}, 32'd0);
        send_frame(0, 1, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
